// File: rtl/pio_host_ctrl.sv
// Host sequencer for one pio: streams program ROM, replays config ROM, then round-robin TX push / RX pull arbitration.
// All outputs registered; requesters are stalled by full/empty flags and a one-cycle per-machine holdoff after each grant.
module pio_host_ctrl #(
  parameter int         PROG_LEN  = 32,
  parameter int         CONF_LEN  = 10,
  parameter logic [3:0] ACT_INSTR = 4'd1,
  parameter logic [3:0] ACT_PUSH  = 4'd4,
  parameter logic [3:0] ACT_PULL  = 4'd5,
  parameter int         PULL_LAT  = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         reload_i,
  output logic [4:0]   prog_addr_o,
  input  logic [15:0]  prog_data_i,
  output logic [4:0]   conf_addr_o,
  input  logic [37:0]  conf_data_i,
  output logic [31:0]  din_o,
  output logic [4:0]   index_o,
  output logic [3:0]   action_o,
  output logic [1:0]   mindex_o,
  input  logic [3:0]   full_i,
  input  logic [3:0]   empty_i,
  input  logic [31:0]  dout_i,
  input  logic [3:0]   push_req_i,
  input  logic [127:0] push_data_i,
  output logic [3:0]   push_ack_o,
  input  logic [3:0]   pull_req_i,
  output logic [3:0]   pull_ack_o,
  output logic         pull_valid_o,
  output logic [1:0]   pull_id_o,
  output logic [31:0]  pull_data_o,
  output logic         ready_o
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_CONF = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [5:0] PROG_N    = 6'(PROG_LEN);
  localparam logic [5:0] PROG_LAST = 6'(PROG_LEN - 1);
  localparam logic [5:0] CONF_N    = 6'(CONF_LEN);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  prog_addr_q, prog_addr_d;
  logic [4:0]  conf_addr_q, conf_addr_d;
  logic [31:0] din_q, din_d;
  logic [4:0]  index_q, index_d;
  logic [3:0]  action_q, action_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [3:0]  push_ack_q, push_ack_d;
  logic [3:0]  pull_ack_q, pull_ack_d;
  logic        pull_valid_q, pull_valid_d;
  logic [1:0]  pull_id_q, pull_id_d;
  logic [31:0] pull_data_q, pull_data_d;
  logic        ready_q, ready_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  toggle_q, toggle_d;
  logic        pull_issue;

  logic [PULL_LAT-1:0]       pipe_vld_q, pipe_vld_d;
  logic [PULL_LAT-1:0][1:0]  pipe_id_q, pipe_id_d;

  logic [3:0] push_ok, pull_ok, elig;
  logic       gnt_vld, gnt_op;
  logic [1:0] gnt_id;

  // The ack register doubles as the "granted last cycle" holdoff mask.
  assign push_ok = push_req_i & ~full_i;
  assign pull_ok = pull_req_i & ~empty_i;
  assign elig    = (push_ok | pull_ok) & ~(push_ack_q | pull_ack_q);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[rr_q + 2'(k)]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q + 2'(k);
      end
    end
    gnt_op = (push_ok[gnt_id] && pull_ok[gnt_id]) ? ~toggle_q[gnt_id] : pull_ok[gnt_id];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prog_addr_d = prog_addr_q;
    conf_addr_d = conf_addr_q;
    din_d       = '0;
    index_d     = '0;
    action_d    = '0;
    mindex_d    = '0;
    push_ack_d  = '0;
    pull_ack_d  = '0;
    rr_d        = rr_q;
    toggle_d    = toggle_q;
    pull_issue  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q < PROG_N) begin
          action_d = ACT_INSTR;
          index_d  = cnt_q[4:0];
          din_d    = {16'h0, prog_data_i};
          if (cnt_q < PROG_LAST) prog_addr_d = cnt_q[4:0] + 5'd1;
        end else begin
          // conf_addr has sat at 0 during LOAD, so word 0 is already on conf_data.
          action_d = conf_data_i[35:32];
          din_d    = conf_data_i[31:0];
          mindex_d = conf_data_i[37:36];
          state_d  = ST_CONF;
          cnt_d    = 6'd1;
          if (CONF_N > 6'd1) conf_addr_d = 5'd1;
        end
      end
      ST_CONF: begin
        if (cnt_q < CONF_N) begin
          action_d = conf_data_i[35:32];
          din_d    = conf_data_i[31:0];
          mindex_d = conf_data_i[37:36];
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q + 6'd1 < CONF_N) conf_addr_d = 5'(cnt_q + 6'd1);
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (reload_i) begin
          state_d     = ST_LOAD;
          cnt_d       = '0;
          prog_addr_d = '0;
          conf_addr_d = '0;
        end else if (gnt_vld) begin
          action_d           = gnt_op ? ACT_PULL : ACT_PUSH;
          mindex_d           = gnt_id;
          din_d              = gnt_op ? 32'h0 : push_data_i[{gnt_id, 5'd0} +: 32];
          push_ack_d[gnt_id] = ~gnt_op;
          pull_ack_d[gnt_id] = gnt_op;
          toggle_d[gnt_id]   = gnt_op;
          rr_d               = gnt_id + 2'd1;
          pull_issue         = gnt_op;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Stage 0 loads alongside the PULL action; the last stage marks dout as valid.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = pull_issue;
    pipe_id_d[0]  = gnt_id;
    for (int k = 1; k < PULL_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_id_d[k]  = pipe_id_q[k-1];
    end
    pull_valid_d = pipe_vld_q[PULL_LAT-1];
    pull_id_d    = pipe_vld_q[PULL_LAT-1] ? pipe_id_q[PULL_LAT-1] : pull_id_q;
    pull_data_d  = pipe_vld_q[PULL_LAT-1] ? dout_i : pull_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      prog_addr_q  <= '0;
      conf_addr_q  <= '0;
      din_q        <= '0;
      index_q      <= '0;
      action_q     <= '0;
      mindex_q     <= '0;
      push_ack_q   <= '0;
      pull_ack_q   <= '0;
      pull_valid_q <= 1'b0;
      pull_id_q    <= '0;
      pull_data_q  <= '0;
      ready_q      <= 1'b0;
      rr_q         <= '0;
      toggle_q     <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prog_addr_q  <= prog_addr_d;
      conf_addr_q  <= conf_addr_d;
      din_q        <= din_d;
      index_q      <= index_d;
      action_q     <= action_d;
      mindex_q     <= mindex_d;
      push_ack_q   <= push_ack_d;
      pull_ack_q   <= pull_ack_d;
      pull_valid_q <= pull_valid_d;
      pull_id_q    <= pull_id_d;
      pull_data_q  <= pull_data_d;
      ready_q      <= ready_d;
      rr_q         <= rr_d;
      toggle_q     <= toggle_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign prog_addr_o  = prog_addr_q;
  assign conf_addr_o  = conf_addr_q;
  assign din_o        = din_q;
  assign index_o      = index_q;
  assign action_o     = action_q;
  assign mindex_o     = mindex_q;
  assign push_ack_o   = push_ack_q;
  assign pull_ack_o   = pull_ack_q;
  assign pull_valid_o = pull_valid_q;
  assign pull_id_o    = pull_id_q;
  assign pull_data_o  = pull_data_q;
  assign ready_o      = ready_q;

endmodule

// File: tb/tb_pio_host_ctrl.sv
// Directed bench for pio_host_ctrl: load/config sequencing, run-phase vector table, reload and mid-load reset.
module tb_pio_host_ctrl;

  logic         clk = 1'b0;
  logic         reset, reload;
  logic [4:0]   prog_addr, conf_addr, index;
  logic [15:0]  prog_data;
  logic [37:0]  conf_data;
  logic [31:0]  din, dout, pull_data;
  logic [3:0]   action, full, empty, push_req, pull_req, push_ack, pull_ack;
  logic [1:0]   mindex, pull_id;
  logic [127:0] push_data;
  logic         pull_valid, ready;

  logic [15:0] prog_rom [32];
  logic [37:0] conf_rom [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  pu, pl, fu, em;
    logic [3:0]  e_act;
    logic [1:0]  e_mi;
    logic [31:0] e_din;
    logic [3:0]  e_pack, e_lack;
    logic        e_pv;
    logic [1:0]  e_pid;
  } vec_t;

  vec_t vt [21];

  always #5 clk = ~clk;

  assign prog_data = prog_rom[prog_addr];
  assign conf_data = conf_rom[conf_addr];

  pio_host_ctrl dut (
    .clk_i(clk), .reset_i(reset), .reload_i(reload),
    .prog_addr_o(prog_addr), .prog_data_i(prog_data),
    .conf_addr_o(conf_addr), .conf_data_i(conf_data),
    .din_o(din), .index_o(index), .action_o(action), .mindex_o(mindex),
    .full_i(full), .empty_i(empty), .dout_i(dout),
    .push_req_i(push_req), .push_data_i(push_data), .push_ack_o(push_ack),
    .pull_req_i(pull_req), .pull_ack_o(pull_ack),
    .pull_valid_o(pull_valid), .pull_id_o(pull_id), .pull_data_o(pull_data),
    .ready_o(ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] pu, pl, fu, em, ea, input logic [1:0] mi,
                              input logic [31:0] di, input logic [3:0] pa, la,
                              input logic pv, input logic [1:0] pid);
    vec_t v;
    v.pu = pu; v.pl = pl; v.fu = fu; v.em = em;
    v.e_act = ea; v.e_mi = mi; v.e_din = di; v.e_pack = pa; v.e_lack = la;
    v.e_pv = pv; v.e_pid = pid;
    return v;
  endfunction

  // Called in the first cycle after the reset edge; reset is released here.
  task automatic run_load();
    logic [37:0] w;
    reset = 1'b0;
    chk("rst_prog_addr", 64'(prog_addr), 64'd0);
    chk("rst_conf_addr", 64'(conf_addr), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk("rst_index", 64'(index), 64'd0);
    chk("rst_action", 64'(action), 64'd0);
    chk("rst_mindex", 64'(mindex), 64'd0);
    chk("rst_push_ack", 64'(push_ack), 64'd0);
    chk("rst_pull_ack", 64'(pull_ack), 64'd0);
    chk("rst_pull_valid", 64'(pull_valid), 64'd0);
    chk("rst_pull_id", 64'(pull_id), 64'd0);
    chk("rst_pull_data", 64'(pull_data), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    for (int t = 1; t <= 43; t++) begin
      step();
      if (t <= 32) begin
        chk("load_action", 64'(action), 64'd1);
        chk("load_index", 64'(index), 64'(t - 1));
        chk("load_din", 64'(din), 64'({16'h0, prog_rom[t-1]}));
        chk("load_mindex", 64'(mindex), 64'd0);
      end else if (t <= 42) begin
        w = conf_rom[t-33];
        chk("conf_action", 64'(action), 64'(w[35:32]));
        chk("conf_din", 64'(din), 64'(w[31:0]));
        chk("conf_mindex", 64'(mindex), 64'(w[37:36]));
        chk("conf_index", 64'(index), 64'd0);
      end else begin
        chk("run_first_action", 64'(action), 64'd0);
      end
      if (t <= 31) chk("load_prog_addr", 64'(prog_addr), 64'(t));
      if (t >= 33 && t <= 41) chk("conf_addr", 64'(conf_addr), 64'(t - 32));
      chk("load_ready", 64'(ready), (t == 43) ? 64'd1 : 64'd0);
      chk("load_push_ack", 64'(push_ack), 64'd0);
      chk("load_pull_ack", 64'(pull_ack), 64'd0);
      chk("load_pull_valid", 64'(pull_valid), 64'd0);
    end
  endtask

  task automatic run_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      push_req = vt[i].pu;
      pull_req = vt[i].pl;
      full     = vt[i].fu;
      empty    = vt[i].em;
      step();
      chk($sformatf("v%0d_action", i + 1), 64'(action), 64'(vt[i].e_act));
      chk($sformatf("v%0d_push_ack", i + 1), 64'(push_ack), 64'(vt[i].e_pack));
      chk($sformatf("v%0d_pull_ack", i + 1), 64'(pull_ack), 64'(vt[i].e_lack));
      chk($sformatf("v%0d_pull_valid", i + 1), 64'(pull_valid), 64'(vt[i].e_pv));
      if (vt[i].e_act != 4'd0) begin
        chk($sformatf("v%0d_mindex", i + 1), 64'(mindex), 64'(vt[i].e_mi));
        chk($sformatf("v%0d_din", i + 1), 64'(din), 64'(vt[i].e_din));
      end
      if (vt[i].e_pv) begin
        chk($sformatf("v%0d_pull_id", i + 1), 64'(pull_id), 64'(vt[i].e_pid));
        chk($sformatf("v%0d_pull_data", i + 1), 64'(pull_data), 64'h0000_0000_A5A5_0001);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      prog_rom[i] = 16'hA000 ^ 16'(i * 1111);
      conf_rom[i] = '0;
    end
    for (int j = 0; j < 10; j++)
      conf_rom[j] = {2'(j), ((j % 3) == 1) ? 4'd0 : 4'(j + 2), 32'hC0DE_0000 + 32'(j * 17)};

    //           push     pull     full     empty    act   mi    din            pack     lack     pv    pid
    vt[0]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd0, 32'hDA7A_0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    vt[1]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd1, 32'hDA7A_0001, 4'b0010, 4'b0000, 1'b0, 2'd0);
    vt[2]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd2, 32'hDA7A_0002, 4'b0100, 4'b0000, 1'b0, 2'd0);
    vt[3]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd3, 32'hDA7A_0003, 4'b1000, 4'b0000, 1'b0, 2'd0);
    vt[4]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd0, 32'hDA7A_0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    vt[5]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[6]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[7]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd2, 32'hDA7A_0002, 4'b0100, 4'b0000, 1'b0, 2'd0);
    vt[8]  = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd5, 2'd1, 32'h0,         4'b0000, 4'b0010, 1'b0, 2'd0);
    vt[9]  = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[10] = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd4, 2'd1, 32'hDA7A_0001, 4'b0010, 4'b0000, 1'b0, 2'd0);
    vt[11] = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[12] = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd5, 2'd1, 32'h0,         4'b0000, 4'b0010, 1'b0, 2'd0);
    vt[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[14] = mk(4'b0010, 4'b0010, 4'b0000, 4'b1111, 4'd4, 2'd1, 32'hDA7A_0001, 4'b0010, 4'b0000, 1'b0, 2'd0);
    vt[15] = mk(4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[16] = mk(4'b0010, 4'b0010, 4'b0000, 4'b1101, 4'd5, 2'd1, 32'h0,         4'b0000, 4'b0010, 1'b0, 2'd0);
    vt[17] = mk(4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'd0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[18] = mk(4'b1001, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd3, 32'hDA7A_0003, 4'b1000, 4'b0000, 1'b0, 2'd0);
    vt[19] = mk(4'b1001, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd0, 32'hDA7A_0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    vt[20] = mk(4'b1001, 4'b0000, 4'b0000, 4'b1111, 4'd4, 2'd3, 32'hDA7A_0003, 4'b1000, 4'b0000, 1'b0, 2'd0);

    reset     = 1'b1;
    reload    = 1'b0;
    full      = 4'b0000;
    empty     = 4'b1111;
    push_req  = 4'b1111;
    pull_req  = 4'b0000;
    dout      = 32'hA5A5_0001;
    push_data = {32'hDA7A_0003, 32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};
    repeat (3) step();

    run_load();
    run_vecs(21);

    // Pull on machine 2, then reload while its data is still in flight.
    push_req = 4'b0000; pull_req = 4'b0100; empty = 4'b1011;
    step();
    chk("rl_pull_action", 64'(action), 64'd5);
    chk("rl_pull_mindex", 64'(mindex), 64'd2);
    chk("rl_pull_ack", 64'(pull_ack), 64'b0100);
    reload = 1'b1; pull_req = 4'b0000; push_req = 4'b0001; empty = 4'b1111;
    step();
    chk("rl_ready", 64'(ready), 64'd0);
    chk("rl_action", 64'(action), 64'd0);
    chk("rl_push_ack", 64'(push_ack), 64'd0);
    chk("rl_pull_valid", 64'(pull_valid), 64'd1);
    chk("rl_pull_id", 64'(pull_id), 64'd2);
    chk("rl_pull_data", 64'(pull_data), 64'h0000_0000_A5A5_0001);
    chk("rl_prog_addr", 64'(prog_addr), 64'd0);
    push_req = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      reload = (k == 4);
      step();
      chk("rl_load_action", 64'(action), 64'd1);
      chk("rl_load_index", 64'(index), 64'(k - 1));
      chk("rl_load_prog_addr", 64'(prog_addr), 64'(k));
      chk("rl_load_ready", 64'(ready), 64'd0);
      chk("rl_load_push_ack", 64'(push_ack), 64'd0);
    end
    reload = 1'b0;

    // Reset in LOAD cycle 10: outputs clear and the whole sequence restarts.
    reset = 1'b1;
    push_req = 4'b1111;
    step();
    run_load();
    run_vecs(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
